mrv1_wb_arbiter: RTL and testbench

Writeback arbiter for the multithreaded mtcore execute stage. It collects completion pulses from every functional unit (ALU, MUL, and later units), each carrying a result, itag and thread-warp id. It holds each completion in a one-entry slot per unit, then grants the single register-file writeback port round-robin. It sits between `mrv1_exec` outputs and the register file / scoreboard release logic, and back-pressures each unit through a per-unit ready.

---
 rtl/mrv1_pkg.sv | 23 ++
 rtl/mrv1_rr_arb.sv | 38 +++
 rtl/mrv1_wb_arbiter.sv | 103 ++++++++++
 tb/tb_mrv1_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrv1_pkg.sv
// Shared mtcore execute-stage definitions: functional-unit indices and the
// writeback bundle carried from each unit's slot to the register file.
package mrv1_pkg;

    // Unit indices; MRV1_NUM_FU stays last so it always equals the unit count.
    typedef enum int {
        MRV1_FU_ALU = 0,
        MRV1_FU_MUL = 1,
        MRV1_NUM_FU = 2
    } mrv1_fu_e;

    localparam int MRV1_DATA_WIDTH = 32;
    localparam int MRV1_ITAG_WIDTH = 3;
    localparam int MRV1_NUM_TW     = 4;
    localparam int MRV1_TWID_WIDTH = $clog2(MRV1_NUM_TW);

    typedef struct packed {
        logic [MRV1_DATA_WIDTH-1:0] data;
        logic [MRV1_ITAG_WIDTH-1:0] itag;
        logic [MRV1_TWID_WIDTH-1:0] twid;
    } mrv1_wb_t;

endpackage

// File: rtl/mrv1_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
// The pointer register lives in the caller.
module mrv1_rr_arb #(
    parameter  int NUM_REQ_P    = 2,
    localparam int idx_width_lp = $clog2(NUM_REQ_P)
) (
    input  logic [NUM_REQ_P-1:0]    req,
    input  logic [idx_width_lp-1:0] ptr,
    output logic [NUM_REQ_P-1:0]    gnt_oh,
    output logic [idx_width_lp-1:0] gnt_idx,
    output logic                    any
);

    // ptr is always below NUM_REQ_P, so one conditional subtract wraps the
    // search index without a general modulo.
    always_comb begin
        int   j;
        logic found;
        // NOTE: every output gets a default before the loop so no path leaves
        // one unassigned, which would otherwise infer a latch.
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ_P; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ_P) j = j - NUM_REQ_P;
            if (!found && req[j]) begin
                found     = 1'b1;
                gnt_oh[j] = 1'b1;
                gnt_idx   = idx_width_lp'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mrv1_wb_arbiter.sv
// Writeback arbiter: one holding slot per functional unit, drained round-robin
// onto the single register-file writeback port with per-unit back-pressure.
module mrv1_wb_arbiter
    import mrv1_pkg::*;
#(
    parameter  int NUM_FU_P        = int'(MRV1_NUM_FU),
    parameter  int NUM_TW_P        = MRV1_NUM_TW,
    parameter  int DATA_WIDTH_P    = MRV1_DATA_WIDTH,
    parameter  int ITAG_WIDTH_P    = MRV1_ITAG_WIDTH,
    localparam int twid_width_lp   = $clog2(NUM_TW_P),
    localparam int fu_idx_width_lp = $clog2(NUM_FU_P)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_FU_P-1:0]                   fu_done_i,
    input  logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0] fu_res_data_i,
    input  logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0] fu_itag_i,
    input  logic [NUM_FU_P-1:0][twid_width_lp-1:0] fu_twid_i,
    output logic [NUM_FU_P-1:0]                   fu_rdy_o,
    output logic                                  wb_vld_o,
    input  logic                                  wb_rdy_i,
    output logic [DATA_WIDTH_P-1:0]               wb_data_o,
    output logic [ITAG_WIDTH_P-1:0]               wb_itag_o,
    output logic [twid_width_lp-1:0]              wb_twid_o,
    output logic [fu_idx_width_lp-1:0]            wb_fu_o
);

    logic [NUM_FU_P-1:0]        slot_vld;
    mrv1_wb_t                   slot [NUM_FU_P];
    logic [fu_idx_width_lp-1:0] ptr;

    logic [NUM_FU_P-1:0]        gnt_oh;
    logic [fu_idx_width_lp-1:0] gnt_idx;
    logic                       any_vld;
    logic                       hs;
    logic [NUM_FU_P-1:0]        drain;
    logic [NUM_FU_P-1:0]        capture;

    mrv1_rr_arb #(
        .NUM_REQ_P(NUM_FU_P)
    ) u_rr_arb (
        .req    (slot_vld),
        .ptr    (ptr),
        .gnt_oh (gnt_oh),
        .gnt_idx(gnt_idx),
        .any    (any_vld)
    );

    assign hs       = any_vld & wb_rdy_i;
    assign drain    = gnt_oh & {NUM_FU_P{hs}};
    // A slot that drains this cycle can take a new result on the same edge.
    assign fu_rdy_o = ~slot_vld | drain;
    assign capture  = fu_done_i & fu_rdy_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_vld <= '0;
            ptr      <= '0;
        end else begin
            slot_vld <= (slot_vld & ~drain) | capture;
            if (hs) begin
                ptr <= (gnt_idx == fu_idx_width_lp'(NUM_FU_P - 1))
                     ? '0 : gnt_idx + fu_idx_width_lp'(1);
            end
        end
    end

    // NOTE: slot payloads carry no reset; slot_vld alone says whether a slot
    // holds anything, and the output mux forces zeros when nothing is valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_FU_P; i++) begin
            if (capture[i]) begin
                slot[i].data <= MRV1_DATA_WIDTH'(fu_res_data_i[i]);
                slot[i].itag <= MRV1_ITAG_WIDTH'(fu_itag_i[i]);
                slot[i].twid <= MRV1_TWID_WIDTH'(fu_twid_i[i]);
            end
        end
    end

    always_comb begin
        wb_vld_o  = any_vld;
        wb_data_o = '0;
        wb_itag_o = '0;
        wb_twid_o = '0;
        wb_fu_o   = '0;
        if (any_vld) begin
            wb_data_o = slot[gnt_idx].data[DATA_WIDTH_P-1:0];
            wb_itag_o = slot[gnt_idx].itag[ITAG_WIDTH_P-1:0];
            wb_twid_o = slot[gnt_idx].twid[twid_width_lp-1:0];
            wb_fu_o   = gnt_idx;
        end
    end

    // A unit completing into a full, non-draining slot loses its result.
    for (genvar i = 0; i < NUM_FU_P; i++) begin : g_proto
        assert property (@(posedge clk_i) disable iff (rst_i)
                         !(fu_done_i[i] && !fu_rdy_o[i]))
            else $error("mrv1_wb_arbiter: fu_done_i[%0d] asserted while not ready", i);
    end

endmodule

// File: tb/tb_mrv1_wb_arbiter.sv
// Bench for mrv1_wb_arbiter: directed vector table, reset corner sequence,
// then randomized traffic against a per-unit queue model.
module tb_mrv1_wb_arbiter;

    localparam int NFU = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NFU-1:0]       fu_done;
    logic [NFU-1:0][31:0] fu_data;
    logic [NFU-1:0][2:0]  fu_itag;
    logic [NFU-1:0][1:0]  fu_twid;
    logic [NFU-1:0]       fu_rdy;
    logic                 wb_vld;
    logic                 wb_rdy;
    logic [31:0]          wb_data;
    logic [2:0]           wb_itag;
    logic [1:0]           wb_twid;
    logic                 wb_fu;

    int n_pass  = 0;
    int n_total = 0;

    mrv1_wb_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fu_done_i    (fu_done),
        .fu_res_data_i(fu_data),
        .fu_itag_i    (fu_itag),
        .fu_twid_i    (fu_twid),
        .fu_rdy_o     (fu_rdy),
        .wb_vld_o     (wb_vld),
        .wb_rdy_i     (wb_rdy),
        .wb_data_o    (wb_data),
        .wb_itag_o    (wb_itag),
        .wb_twid_o    (wb_twid),
        .wb_fu_o      (wb_fu)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  done;
        logic [31:0] d0, d1;
        logic [2:0]  i0, i1;
        logic [1:0]  t0, t1;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_data;
        logic [2:0]  e_itag;
        logic [1:0]  e_twid;
        logic        e_fu;
        logic [1:0]  e_rdy;
    } vec_t;

    vec_t vecs [19];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  itag;
        logic [1:0]  twid;
    } res_t;

    res_t     q [NFU][$];
    int       ptr_m;
    int       g_m;
    logic     vld_m;
    logic     hs_m;
    logic [NFU-1:0] rdy_m;
    int       prev_g;
    int       issued;
    int       retired;
    logic [2:0] itag_cnt [NFU];

    function automatic int m_grant();
        for (int k = 0; k < NFU; k++) begin
            int u;
            u = (ptr_m + k) % NFU;
            if (q[u].size() != 0) return u;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NFU; u++) begin
            q[u].delete();
            itag_cnt[u] = 3'd0;
        end
        ptr_m   = 0;
        prev_g  = -1;
        issued  = 0;
        retired = 0;
    endtask

    task automatic model_eval();
        g_m   = m_grant();
        vld_m = (g_m >= 0);
        hs_m  = vld_m && wb_rdy;
        for (int u = 0; u < NFU; u++)
            rdy_m[u] = (q[u].size() == 0) || (u == g_m && hs_m);
    endtask

    task automatic model_compare(input int mode);
        res_t exp_r;
        exp_r = '0;
        if (vld_m) exp_r = q[g_m][0];
        check("rand_vld",  64'(wb_vld),  64'(vld_m));
        check("rand_data", 64'(wb_data), 64'(exp_r.data));
        check("rand_itag", 64'(wb_itag), 64'(exp_r.itag));
        check("rand_twid", 64'(wb_twid), 64'(exp_r.twid));
        check("rand_fu",   64'(wb_fu),   64'(vld_m ? g_m : 0));
        check("rand_rdy",  64'(fu_rdy),  64'(rdy_m));
        if (mode == 0 && prev_g >= 0 && vld_m)
            check("alternate_fu", 64'(wb_fu), 64'((prev_g + 1) % NFU));
    endtask

    task automatic model_commit();
        if (hs_m) begin
            void'(q[g_m].pop_front());
            ptr_m = (g_m + 1) % NFU;
            retired++;
        end
        prev_g = hs_m ? g_m : -1;
        for (int u = 0; u < NFU; u++) begin
            if (fu_done[u] && rdy_m[u]) begin
                q[u].push_back(res_t'{data: fu_data[u], itag: fu_itag[u], twid: fu_twid[u]});
                issued++;
            end
        end
    endtask

    // mode 0: every unit completes whenever allowed, rdy always high
    // mode 1: random completions and random back-pressure
    // mode 2: drain only
    task automatic rand_cycle(input int mode);
        wb_rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        model_eval();
        for (int u = 0; u < NFU; u++) begin
            fu_data[u] = $urandom;
            fu_twid[u] = 2'($urandom);
            fu_itag[u] = (mode == 0) ? itag_cnt[u] : 3'($urandom);
            fu_done[u] = (mode == 0) ? rdy_m[u]
                       : (mode == 1) ? (rdy_m[u] && $urandom_range(0, 1) == 1) : 1'b0;
            if (mode == 0 && fu_done[u]) itag_cnt[u] = itag_cnt[u] + 3'd1;
        end
        @(negedge clk);
        model_compare(mode);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    initial begin
        // {done, d0, d1, i0, i1, t0, t1, rdy, e_vld, e_data, e_itag, e_twid, e_fu, e_rdy}
        vecs[0]  = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[1]  = '{2'b01, 32'h1234, 32'h0,  3'd5, 3'd0, 2'd2, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[2]  = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'h1234, 3'd5, 2'd2, 1'b0, 2'b11};
        vecs[3]  = '{2'b10, 32'h0,    32'h55, 3'd0, 3'd1, 2'd0, 2'd3, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[4]  = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'h55,   3'd1, 2'd3, 1'b1, 2'b11};
        vecs[5]  = '{2'b11, 32'hA0,   32'hB0, 3'd2, 3'd3, 2'd1, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[6]  = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'hA0,   3'd2, 2'd1, 1'b0, 2'b01};
        vecs[7]  = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'hB0,   3'd3, 2'd0, 1'b1, 2'b11};
        vecs[8]  = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[9]  = '{2'b10, 32'h0,    32'hC1, 3'd0, 3'd4, 2'd0, 2'd1, 1'b0, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[10] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 32'hC1,   3'd4, 2'd1, 1'b1, 2'b01};
        vecs[11] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 32'hC1,   3'd4, 2'd1, 1'b1, 2'b01};
        vecs[12] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 32'hC1,   3'd4, 2'd1, 1'b1, 2'b01};
        vecs[13] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'hC1,   3'd4, 2'd1, 1'b1, 2'b11};
        vecs[14] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[15] = '{2'b01, 32'h11,   32'h0,  3'd1, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};
        vecs[16] = '{2'b01, 32'hAA,   32'h0,  3'd6, 3'd0, 2'd3, 2'd0, 1'b1, 1'b1, 32'h11,   3'd1, 2'd0, 1'b0, 2'b11};
        vecs[17] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'hAA,   3'd6, 2'd3, 1'b0, 2'b11};
        vecs[18] = '{2'b00, 32'h0,    32'h0,  3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0,    3'd0, 2'd0, 1'b0, 2'b11};

        rst     = 1'b1;
        fu_done = '0;
        fu_data = '0;
        fu_itag = '0;
        fu_twid = '0;
        wb_rdy  = 1'b0;
        @(negedge clk);
        check("reset_vld",  64'(wb_vld),  64'd0);
        check("reset_rdy",  64'(fu_rdy),  64'b11);
        check("reset_data", 64'(wb_data), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < 19; r++) begin
            fu_done    = vecs[r].done;
            fu_data[0] = vecs[r].d0;
            fu_data[1] = vecs[r].d1;
            fu_itag[0] = vecs[r].i0;
            fu_itag[1] = vecs[r].i1;
            fu_twid[0] = vecs[r].t0;
            fu_twid[1] = vecs[r].t1;
            wb_rdy     = vecs[r].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_vld", r),  64'(wb_vld),  64'(vecs[r].e_vld));
            check($sformatf("vec%0d_data", r), 64'(wb_data), 64'(vecs[r].e_data));
            check($sformatf("vec%0d_itag", r), 64'(wb_itag), 64'(vecs[r].e_itag));
            check($sformatf("vec%0d_twid", r), 64'(wb_twid), 64'(vecs[r].e_twid));
            check($sformatf("vec%0d_fu", r),   64'(wb_fu),   64'(vecs[r].e_fu));
            check($sformatf("vec%0d_rdy", r),  64'(fu_rdy),  64'(vecs[r].e_rdy));
            @(posedge clk);
            #1;
        end

        // Reset mid-stream: pointer is at 1 here, both slots get filled, then
        // an asynchronous reset lands between clock edges.
        fu_done    = 2'b11;
        fu_data[0] = 32'hD0;
        fu_data[1] = 32'hD1;
        wb_rdy     = 1'b0;
        @(posedge clk);
        #1 fu_done = 2'b00;
        @(negedge clk);
        check("pre_rst_vld", 64'(wb_vld), 64'd1);
        check("pre_rst_fu",  64'(wb_fu),  64'd1);
        check("pre_rst_rdy", 64'(fu_rdy), 64'b00);
        #2 rst = 1'b1;
        #1;
        check("async_rst_vld",  64'(wb_vld),  64'd0);
        check("async_rst_rdy",  64'(fu_rdy),  64'b11);
        check("async_rst_data", 64'(wb_data), 64'd0);
        check("async_rst_fu",   64'(wb_fu),   64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        fu_done = 2'b11;
        wb_rdy  = 1'b1;
        @(posedge clk);
        #1 fu_done = 2'b00;
        @(negedge clk);
        check("post_rst_fu0",   64'(wb_fu),   64'd0);
        check("post_rst_data0", 64'(wb_data), 64'hD0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_fu1",   64'(wb_fu),   64'd1);
        check("post_rst_data1", 64'(wb_data), 64'hD1);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_idle",  64'(wb_vld),  64'd0);
        @(posedge clk);
        #1;

        // Randomized phases against the queue model, from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 24; c++)  rand_cycle(0);
        for (int c = 0; c < 400; c++) rand_cycle(1);
        for (int c = 0; c < 8; c++) begin
            if (q[0].size() == 0 && q[1].size() == 0) break;
            rand_cycle(2);
        end
        check("drain_empty", 64'(q[0].size() + q[1].size()), 64'd0);
        check("no_result_lost", 64'(retired), 64'(issued));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
